// File: rtl/output_deskew_writeback.sv
// -----------------------------------------------------------------------------
// output_deskew_writeback
//
// Sits under the bottom edge of the systolic array. Each array column delivers
// its result one cycle after its left neighbour, so a row arrives diagonally
// skewed. This block realigns a row, optionally adds a partial-sum row read
// from psum memory, masks unused columns, and writes the row to output memory.
//
// Pipeline for a row whose column 0 is sampled in cycle T:
//   T+COL    S1 holds the aligned row; psum read issued when accumulating
//   T+COL+1  psum data returns; sum/mask captured into the write register
//   T+COL+2  o_we asserted with o_addr = o_offset_w + wr_row
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             job start pulse; cfg_* sampled in the same cycle
//   cfg_i_rows        rows to write in this job (0 completes immediately)
//   cfg_w_cols        active columns; columns >= cfg_w_cols are written as 0
//   cfg_psum_offset   psum memory base address
//   cfg_o_offset_w    output memory base address
//   cfg_accum_en      add the psum row before writing
//   arr_valid         per-column result valid (column c lags column c-1 by 1)
//   arr_data          per-column results, column c at [c*ACC_W +: ACC_W]
//   psum_re/addr      psum memory read port request
//   psum_rdata        psum read data, one cycle after psum_re
//   o_we/addr/wdata   output memory write port
//   busy              job in progress (RUN or DONE)
//   done              one-cycle pulse after the last row is written
// -----------------------------------------------------------------------------
module output_deskew_writeback #(
    parameter int COL     = 4,
    parameter int ACC_W   = 20,
    parameter int O_SIZE  = 512,
    parameter int I_SIZE  = 512,
    parameter int MAX_COL = 8,
    parameter int AW      = $clog2(O_SIZE),
    parameter int RW      = $clog2(I_SIZE),
    parameter int CW      = $clog2(MAX_COL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [RW-1:0]        cfg_i_rows,
    input  logic [CW-1:0]        cfg_w_cols,
    input  logic [AW-1:0]        cfg_psum_offset,
    input  logic [AW-1:0]        cfg_o_offset_w,
    input  logic                 cfg_accum_en,
    input  logic [COL-1:0]       arr_valid,
    input  logic [COL*ACC_W-1:0] arr_data,
    output logic                 psum_re,
    output logic [AW-1:0]        psum_addr,
    input  logic [COL*ACC_W-1:0] psum_rdata,
    output logic                 o_we,
    output logic [AW-1:0]        o_addr,
    output logic [COL*ACC_W-1:0] o_wdata,
    output logic                 busy,
    output logic                 done
);

    typedef logic [COL-1:0][ACC_W-1:0] row_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    typedef struct packed {
        logic [RW-1:0] rows;
        logic [CW-1:0] w_cols;
        logic [AW-1:0] psum_off;
        logic [AW-1:0] o_off;
        logic          accum;
    } cfg_t;

    state_t        state_q, state_d;
    cfg_t          cfg_q, cfg_d;
    logic [RW-1:0] rd_row_q, rd_row_d;
    logic [RW-1:0] wr_row_q, wr_row_d;

    // Triangular delay line: dl_q[k] carries columns 0..k; column c enters at
    // stage c and leaves stage COL-2, giving it COL-1-c stages before S1.
    row_t          dl_q [COL-1];
    row_t          dl_d [COL-1];

    logic          s1_v_q, s1_v_d;
    row_t          s1_q, s1_d;
    logic          p_v_q, p_v_d;      // row waiting for its psum data
    row_t          p_q, p_d;
    logic          o_we_q, o_we_d;
    logic [AW-1:0] o_addr_q, o_addr_d;
    row_t          o_wdata_q, o_wdata_d;

    row_t          in_row;
    row_t          psum_row;
    logic          s1_take;
    logic [ACC_W-1:0] elem;

    assign in_row   = arr_data;
    assign psum_row = psum_rdata;

    always_comb begin
        // NOTE: every next-state value starts from a default so no branch can
        // leave a signal unassigned and infer a latch.
        state_d   = state_q;
        cfg_d     = cfg_q;
        rd_row_d  = rd_row_q;
        wr_row_d  = wr_row_q;
        s1_v_d    = arr_valid[COL-1];
        s1_d      = s1_q;
        p_v_d     = 1'b0;
        p_d       = s1_q;
        o_we_d    = p_v_q;
        o_addr_d  = o_addr_q;
        o_wdata_d = o_wdata_q;
        elem      = '0;
        for (int k = 0; k < COL-1; k++) dl_d[k] = '0;

        // Deskew. Column valids other than the last only gate data capture.
        for (int c = 0; c < COL-1; c++) begin
            dl_d[c][c] = arr_valid[c] ? in_row[c] : dl_q[c][c];
            for (int k = c+1; k < COL-1; k++) dl_d[k][c] = dl_q[k-1][c];
        end
        for (int c = 0; c < COL-1; c++) s1_d[c] = dl_q[COL-2][c];
        s1_d[COL-1] = in_row[COL-1];

        // A strobe only counts while running and until the row quota is met.
        s1_take   = s1_v_q && (state_q == S_RUN) && (rd_row_q < cfg_q.rows);
        psum_re   = s1_take && cfg_q.accum;
        psum_addr = cfg_q.psum_off + AW'(rd_row_q);
        if (s1_take) rd_row_d = rd_row_q + RW'(1);
        p_v_d = s1_take;

        // Sum stage: psum data lines up with p_q one cycle after the read.
        if (p_v_q) begin
            for (int c = 0; c < COL; c++) begin
                elem = p_q[c] + (cfg_q.accum ? psum_row[c] : '0);
                o_wdata_d[c] = (c < int'(cfg_q.w_cols)) ? elem : '0;
            end
            o_addr_d = cfg_q.o_off + AW'(wr_row_q);
            wr_row_d = wr_row_q + RW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d    = '{rows: cfg_i_rows, w_cols: cfg_w_cols,
                                 psum_off: cfg_psum_offset, o_off: cfg_o_offset_w,
                                 accum: cfg_accum_en};
                    rd_row_d = '0;
                    wr_row_d = '0;
                    state_d  = (cfg_i_rows == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // wr_row_q already counts the row being written this cycle.
                if (o_we_q && (wr_row_q == cfg_q.rows)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the delay line is small and reset along with its valids,
            // so a mid-job reset leaves no stale row data anywhere.
            state_q   <= S_IDLE;
            cfg_q     <= '0;
            rd_row_q  <= '0;
            wr_row_q  <= '0;
            for (int k = 0; k < COL-1; k++) dl_q[k] <= '0;
            s1_v_q    <= 1'b0;
            s1_q      <= '0;
            p_v_q     <= 1'b0;
            p_q       <= '0;
            o_we_q    <= 1'b0;
            o_addr_q  <= '0;
            o_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            rd_row_q  <= rd_row_d;
            wr_row_q  <= wr_row_d;
            for (int k = 0; k < COL-1; k++) dl_q[k] <= dl_d[k];
            s1_v_q    <= s1_v_d;
            s1_q      <= s1_d;
            p_v_q     <= p_v_d;
            p_q       <= p_d;
            o_we_q    <= o_we_d;
            o_addr_q  <= o_addr_d;
            o_wdata_q <= o_wdata_d;
        end
    end

    assign o_we    = o_we_q;
    assign o_addr  = o_addr_q;
    assign o_wdata = o_wdata_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

endmodule
